// File: rtl/posit_round_encode_16.sv
// Round-to-nearest-even posit<N,ES> encoder: stage 1 builds regime/exponent/fraction
// fields with guard/sticky, stage 2 rounds, saturates and applies sign/specials.
module posit_round_encode_16 #(
  parameter int N   = 16,
  parameter int ES  = 1,
  parameter int SFW = 7
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic           i_sign,
  input  logic [SFW-1:0] i_sf,
  input  logic [N:0]     i_frac,
  input  logic           i_zero,
  input  logic           i_nar,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [N-1:0]   o_posit
);

  localparam int MW  = N - 1;
  localparam int W   = 3 * N;
  localparam int PAD = W - 1 - ES - N;
  localparam logic signed [SFW-1:0] SF_HI = SFW'((N - 2) << ES);
  localparam logic signed [SFW:0]   K_ONE = 1;

  logic en;

  // Stage 1 field-build signals
  logic signed [SFW:0] k_ext;
  logic [SFW:0]        run;
  logic                term;
  logic [W-1:0]        fields;
  logic [W-1:0]        shifted;
  logic [W-1:0]        fill_mask;

  // Pipeline registers
  logic          s1_valid_q,  s1_valid_d;
  logic [MW-1:0] s1_mag_q,    s1_mag_d;
  logic          s1_guard_q,  s1_guard_d;
  logic          s1_sticky_q, s1_sticky_d;
  logic          s1_sign_q,   s1_sign_d;
  logic          s1_sat_hi_q, s1_sat_hi_d;
  logic          s1_sat_lo_q, s1_sat_lo_d;
  logic          s1_zero_q,   s1_zero_d;
  logic          s1_nar_q,    s1_nar_d;
  logic          o_valid_q,   o_valid_d;
  logic [N-1:0]  o_posit_q,   o_posit_d;

  // Stage 2 round/encode signals
  logic          round_up;
  logic [N-1:0]  mag_sum;
  logic [MW-1:0] mag_fin;
  logic [N-1:0]  posit_val;

  assign en      = !o_valid_q || i_ready;
  assign o_ready = en;
  assign o_valid = o_valid_q;
  assign o_posit = o_posit_q;

  // The regime is a run of fill bits followed by a terminator; shifting the
  // terminator+exponent+fraction string right by the run length builds it in one step.
  always_comb begin
    k_ext     = $signed({i_sf[SFW-1], i_sf}) >>> ES;
    term      = k_ext[SFW];
    run       = term ? -k_ext : k_ext + K_ONE;
    fields    = {term, i_sf[ES-1:0], i_frac[N-1:0], {PAD{1'b0}}};
    fill_mask = ~({W{1'b1}} >> run);
    shifted   = (fields >> run) | (term ? '0 : fill_mask);
  end

  always_comb begin
    round_up = s1_guard_q && (s1_mag_q[0] || s1_sticky_q);
    mag_sum  = {1'b0, s1_mag_q} + N'(round_up);
    if (s1_sat_hi_q || mag_sum[N-1]) begin
      mag_fin = '1;
    end else if (s1_sat_lo_q || mag_sum == '0) begin
      mag_fin = MW'(1);
    end else begin
      mag_fin = mag_sum[MW-1:0];
    end

    if (s1_nar_q) begin
      posit_val = {1'b1, {MW{1'b0}}};
    end else if (s1_zero_q) begin
      posit_val = '0;
    end else if (s1_sign_q) begin
      posit_val = -{1'b0, mag_fin};
    end else begin
      posit_val = {1'b0, mag_fin};
    end
  end

  // NOTE: every register defaults to its held value first, so a stalled pipeline
  // needs no extra branches and no latch can be inferred from a missed path.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mag_d    = s1_mag_q;
    s1_guard_d  = s1_guard_q;
    s1_sticky_d = s1_sticky_q;
    s1_sign_d   = s1_sign_q;
    s1_sat_hi_d = s1_sat_hi_q;
    s1_sat_lo_d = s1_sat_lo_q;
    s1_zero_d   = s1_zero_q;
    s1_nar_d    = s1_nar_q;
    o_valid_d   = o_valid_q;
    o_posit_d   = o_posit_q;
    if (en) begin
      s1_valid_d  = i_valid;
      s1_mag_d    = shifted[W-1 -: MW];
      s1_guard_d  = shifted[W-1-MW];
      s1_sticky_d = |shifted[W-2-MW:0];
      s1_sign_d   = i_sign;
      s1_sat_hi_d = $signed(i_sf) >= SF_HI;
      s1_sat_lo_d = $signed(i_sf) < -SF_HI;
      s1_zero_d   = i_zero;
      s1_nar_d    = i_nar;
      o_valid_d   = s1_valid_q;
      if (s1_valid_q) o_posit_d = posit_val;
    end
  end

  // NOTE: all pipeline registers, data included, are reset so a reset mid-stream
  // leaves no stale operand that could resurface after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mag_q    <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_sat_hi_q <= 1'b0;
      s1_sat_lo_q <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_nar_q    <= 1'b0;
      o_valid_q   <= 1'b0;
      o_posit_q   <= '0;
    end else begin
      // NOTE: non-blocking updates let both stages advance from the same pre-edge values.
      s1_valid_q  <= s1_valid_d;
      s1_mag_q    <= s1_mag_d;
      s1_guard_q  <= s1_guard_d;
      s1_sticky_q <= s1_sticky_d;
      s1_sign_q   <= s1_sign_d;
      s1_sat_hi_q <= s1_sat_hi_d;
      s1_sat_lo_q <= s1_sat_lo_d;
      s1_zero_q   <= s1_zero_d;
      s1_nar_q    <= s1_nar_d;
      o_valid_q   <= o_valid_d;
      o_posit_q   <= o_posit_d;
    end
  end

endmodule

// File: tb/tb_posit_round_encode_16.sv
// Directed and randomised bench for posit_round_encode_16: hand-computed vectors,
// backpressure, asynchronous reset and a bit-serial reference model with scoreboard.
module tb_posit_round_encode_16;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_sign = 1'b0;
  logic [6:0]  i_sf = '0;
  logic [16:0] i_frac = 17'h10000;
  logic        i_zero = 1'b0;
  logic        i_nar = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [15:0] o_posit;

  int errors = 0;
  int checks = 0;
  int rx_count = 0;
  int sent = 0;
  bit sb_en = 1'b0;
  bit acc = 1'b0;
  bit stall_hold = 1'b0;
  logic [15:0] stall_val;
  logic [15:0] cur_exp = '0;
  logic [15:0] exp_q[$];

  posit_round_encode_16 dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_sign  (i_sign),
    .i_sf    (i_sf),
    .i_frac  (i_frac),
    .i_zero  (i_zero),
    .i_nar   (i_nar),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_posit (o_posit)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: append the posit bit string one bit at a time, then round.
  function automatic logic [15:0] model(input logic s, input logic [6:0] sf,
                                        input logic [16:0] fr, input logic z, input logic n);
    bit str[64];
    int len, k, e, v;
    logic [14:0] m;
    logic g, st;
    if (n) return 16'h8000;
    if (z) return 16'h0000;
    v = int'($signed(sf));
    if (v >= 28) m = 15'h7FFF;
    else if (v < -28) m = 15'h0001;
    else begin
      for (int i = 0; i < 64; i++) str[i] = 1'b0;
      e = v & 1;
      k = (v - e) / 2;
      len = 0;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) str[len++] = 1'b1;
        str[len++] = 1'b0;
      end else begin
        for (int i = 0; i < -k; i++) str[len++] = 1'b0;
        str[len++] = 1'b1;
      end
      str[len++] = e[0];
      for (int b = 15; b >= 0; b--) str[len++] = fr[b];
      for (int i = 0; i < 15; i++) m[14-i] = str[i];
      g = str[15];
      st = 1'b0;
      for (int i = 16; i < 64; i++) st = st | str[i];
      if (g && (m[0] || st) && m != 15'h7FFF) m = m + 15'd1;
    end
    return s ? -{1'b0, m} : {1'b0, m};
  endfunction

  // Scoreboard/monitor: samples on the falling edge, handshakes complete on the next rising edge.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      exp_q.delete();
      stall_hold = 1'b0;
    end else begin
      if (i_valid && !i_zero && !i_nar)
        assert (i_frac[16] === 1'b1) else begin
          errors++;
          $error("FAIL illegal_frac: observed=%h expected=1xxxx", i_frac);
        end
      if (sb_en) begin
        if (stall_hold) check("stall_stable", {15'd0, o_valid, o_posit}, {15'd0, 1'b1, stall_val});
        if (o_valid && !i_ready) begin
          check("ready_drop", o_ready, 0);
          stall_hold = 1'b1;
          stall_val = o_posit;
        end else begin
          stall_hold = 1'b0;
        end
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) check("dup_output", o_posit, 32'hDEAD_BEEF);
          else check("sb_posit", o_posit, exp_q.pop_front());
          rx_count++;
        end
        if (i_valid && o_ready) exp_q.push_back(cur_exp);
      end
    end
  end

  task automatic single(input logic s, input logic [6:0] sf, input logic [16:0] fr,
                        input logic z, input logic n, input logic [15:0] exp, input string tag);
    @(posedge i_clk); #2;
    i_valid = 1'b1; i_sign = s; i_sf = sf; i_frac = fr; i_zero = z; i_nar = n; i_ready = 1'b1;
    @(posedge i_clk); #2;
    i_valid = 1'b0;
    check({tag, "_lat1"}, o_valid, 0);
    @(posedge i_clk); #2;
    check({tag, "_vld"}, o_valid, 1);
    check(tag, o_posit, exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [6:0]  bp_sf[6]  = '{7'd0, 7'd1, 7'd2, 7'd3, 7'h7F, 7'h7E};
  logic [15:0] bp_exp[6] = '{16'h4000, 16'h5000, 16'h6000, 16'h6800, 16'h3000, 16'h2000};

  initial begin
    #13;
    check("reset_ovalid", o_valid, 0);
    check("reset_oposit", o_posit, 0);
    check("reset_oready", o_ready, 1);
    @(posedge i_clk); #3 i_rst_n = 1'b1;

    single(0, 7'd0,  17'h10000, 0, 0, 16'h4000, "sf0");
    single(0, 7'd1,  17'h10000, 0, 0, 16'h5000, "sf1");
    single(0, 7'd2,  17'h10000, 0, 0, 16'h6000, "sf2");
    single(1, 7'd0,  17'h10000, 0, 0, 16'hC000, "neg_sf0");
    single(0, 7'd0,  17'h18000, 0, 0, 16'h4800, "frac1p5");
    single(0, 7'd0,  17'h14000, 0, 0, 16'h4400, "frac1p25");
    single(0, 7'd0,  17'h10008, 0, 0, 16'h4000, "rne_tie_even");
    single(0, 7'd0,  17'h10009, 0, 0, 16'h4001, "rne_sticky");
    single(0, 7'd0,  17'h10018, 0, 0, 16'h4002, "rne_tie_odd");
    single(0, 7'd40, 17'h10000, 0, 0, 16'h7FFF, "sat_hi40");
    single(0, 7'h58, 17'h10000, 0, 0, 16'h0001, "sat_lo40");
    single(1, 7'h58, 17'h10000, 0, 0, 16'hFFFF, "neg_sat_lo40");
    single(1, 7'd5,  17'h10000, 0, 1, 16'h8000, "nar");
    single(1, 7'd5,  17'h10000, 1, 0, 16'h0000, "zero");
    single(0, 7'd5,  17'h10000, 1, 1, 16'h8000, "nar_and_zero");
    single(0, 7'd27, 17'h10000, 0, 0, 16'h7FFE, "sf27");
    single(0, 7'd27, 17'h1FFFF, 0, 0, 16'h7FFF, "sf27_roundup");
    single(0, 7'd28, 17'h10000, 0, 0, 16'h7FFF, "sf28");
    single(0, 7'h64, 17'h10000, 0, 0, 16'h0001, "sf_m28");
    single(0, 7'h65, 17'h10000, 0, 0, 16'h0002, "sf_m27");
    single(0, 7'h63, 17'h1FFFF, 0, 0, 16'h0001, "sf_m29");

    // Backpressure: six back-to-back operands with a 3-cycle downstream stall.
    @(posedge i_clk); #2;
    sb_en = 1'b1; sent = 0; rx_count = 0;
    for (int c = 0; c < 40 && sent < 6; c++) begin
      if (c > 0) begin @(posedge i_clk); #2; end
      i_ready = !(c >= 3 && c < 6);
      i_valid = 1'b1; i_sign = 1'b0; i_zero = 1'b0; i_nar = 1'b0;
      i_frac = 17'h10000; i_sf = bp_sf[sent]; cur_exp = bp_exp[sent];
      @(negedge i_clk);
      if (o_ready) sent++;
    end
    @(posedge i_clk); #2;
    i_valid = 1'b0; i_ready = 1'b1;
    for (int c = 0; c < 50 && rx_count < 6; c++) @(posedge i_clk);
    #2;
    check("bp_count", rx_count, 6);
    check("bp_queue_empty", exp_q.size(), 0);
    sb_en = 1'b0;

    // Asynchronous reset with two operands in flight.
    @(posedge i_clk); #2;
    i_valid = 1'b1; i_sf = 7'd2; i_frac = 17'h10000;
    @(posedge i_clk); #2;
    i_sf = 7'd3;
    @(posedge i_clk); #2;
    i_valid = 1'b0;
    check("rst_inflight_vld", o_valid, 1);
    check("rst_inflight_posit", o_posit, 16'h6000);
    #1 i_rst_n = 1'b0;
    #1;
    check("rst_async_ovalid", o_valid, 0);
    check("rst_async_oposit", o_posit, 0);
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    single(0, 7'd1, 17'h10000, 0, 0, 16'h5000, "post_rst_sf1");

    // Random operands with random downstream readiness.
    @(posedge i_clk); #2;
    sb_en = 1'b1; sent = 0; rx_count = 0; acc = 1'b0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      @(posedge i_clk); #2;
      if (acc) i_valid = 1'b0;
      i_ready = ($urandom_range(0, 3) != 0);
      if (!i_valid && $urandom_range(0, 4) != 0) begin
        int sel, sfv;
        int ext[6] = '{27, -27, 28, -28, 29, -29};
        sel = $urandom_range(0, 15);
        i_sign = 1'($urandom_range(0, 1));
        i_nar = (sel == 0) || (sel == 1 && $urandom_range(0, 1) == 1);
        i_zero = (sel == 1);
        sfv = (sel == 2) ? ext[$urandom_range(0, 5)] : int'($urandom_range(0, 80)) - 40;
        i_sf = 7'(sfv);
        i_frac = {1'b1, 16'($urandom)};
        if (i_zero || i_nar) i_frac[16] = 1'($urandom_range(0, 1));
        cur_exp = model(i_sign, i_sf, i_frac, i_zero, i_nar);
        i_valid = 1'b1;
      end
      @(negedge i_clk);
      acc = i_valid && o_ready;
      if (acc) sent++;
    end
    @(posedge i_clk); #2;
    i_valid = 1'b0; i_ready = 1'b1;
    for (int c = 0; c < 100 && rx_count < sent; c++) @(posedge i_clk);
    #2;
    check("rand_sent", sent, 10000);
    check("rand_count", rx_count, 10000);
    check("rand_queue_empty", exp_q.size(), 0);
    sb_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
